// File: rtl/regfile_pkg.sv
// Shared constants and ecall FSM state type for the multi-port register file.
package regfile_pkg;

  localparam int unsigned ECALL_A0_IDX    = 10;
  localparam int unsigned ECALL_A1_IDX    = 11;
  localparam int unsigned ECALL_SVC_HALT  = 0;
  localparam int unsigned ECALL_SVC_PRINT = 1;

  typedef enum logic [1:0] {
    RUN,
    PRINT,
    HALTED
  } ecall_state_e;

endpackage

// File: rtl/regfile_ecall_fsm.sv
// Ecall service FSM: decodes a0/a1 on ecall_sig into a print pulse or a sticky halt.
module regfile_ecall_fsm
  import regfile_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ecall_sig,
  input  logic [XLEN-1:0] a0,
  input  logic [XLEN-1:0] a1,
  output logic            halt,
  output logic            print_flag,
  output logic            wr_block
);

  ecall_state_e state;
  logic         svc_halt;
  logic         svc_print;

  assign svc_halt  = (a0 == '0) && (a1 == XLEN'(ECALL_SVC_HALT));
  assign svc_print = (a0 == '0) && (a1 == XLEN'(ECALL_SVC_PRINT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      halt       <= 1'b0;
      print_flag <= 1'b0;
      wr_block   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (ecall_sig && svc_halt) begin
            state    <= HALTED;
            halt     <= 1'b1;
            wr_block <= 1'b1;
          end else if (ecall_sig && svc_print) begin
            state      <= PRINT;
            print_flag <= 1'b1;
          end
        end
        PRINT: begin
          state      <= RUN;
          print_flag <= 1'b0;
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state      <= RUN;
          halt       <= 1'b0;
          print_flag <= 1'b0;
          wr_block   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero and an ecall halt/print FSM.
// Optional same-cycle write-to-read bypass when REGFILE_MP_BYPASS_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      wb_en,
  input  logic [NWR*XLEN-1:0] wb_data,
  input  logic [NWR*AW-1:0]   rd_index,
  input  logic [NRD*AW-1:0]   rs_index,
  output logic [NRD*XLEN-1:0] rs_data_out,
  input  logic                ecall_sig,
  output logic                print_flag,
  output logic                halt
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_block;

  // The FSM sees a0/a1 as currently held, so a same-edge write cannot steer it.
  regfile_ecall_fsm #(
    .XLEN(XLEN)
  ) u_ecall_fsm (
    .clk       (clk),
    .rst       (rst),
    .ecall_sig (ecall_sig),
    .a0        (regs[AW'(ECALL_A0_IDX)]),
    .a1        (regs[AW'(ECALL_A1_IDX)]),
    .halt      (halt),
    .print_flag(print_flag),
    .wr_block  (wr_block)
  );

  // Ascending port order lets port 1 override port 0 on an index collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (!wr_block) begin
      for (int unsigned p = 0; p < NWR; p++) begin
        if (wb_en[p] && (rd_index[p*AW +: AW] != '0))
          regs[rd_index[p*AW +: AW]] <= wb_data[p*XLEN +: XLEN];
      end
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [AW-1:0]   src;
    logic [XLEN-1:0] val;

    assign src = rs_index[r*AW +: AW];

    always_comb begin
      val = regs[src];
`ifdef REGFILE_MP_BYPASS_EN
      for (int unsigned p = 0; p < NWR; p++) begin
        if (!wr_block && wb_en[p] && (rd_index[p*AW +: AW] == src))
          val = wb_data[p*XLEN +: XLEN];
      end
`endif
      if (src == '0) val = '0;
    end

    assign rs_data_out[r*XLEN +: XLEN] = val;
  end

endmodule
